// File: rtl/instruction_fetch_queue.sv
// Fetch stage: sequences instruction-memory requests and buffers fetched {pc, instr}
// pairs for decode. Branch redirects flush the buffer and drop any stale in-flight response.
module instruction_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [63:0]             imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect,
    input  logic [63:0]             redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [31:0]             inst_out,
    output logic [63:0]             inst_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    logic [63:0]   fpc;
    logic [63:0]   req_addr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          pop;
    logic          push;
    logic [CW-1:0] count_next;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready & ~redirect;
    assign push       = (state == WAIT) & imem_ack & ~redirect;
    assign count_next = count + CW'(push) - CW'(pop);

    assign imem_req  = (state != IDLE);
    assign imem_addr = req_addr;
    assign inst_out  = instr_mem[rd_ptr];
    assign inst_pc   = pc_mem[rd_ptr];

    // A request is only issued or kept while a buffer slot is reserved for it,
    // so a push can never land on a full buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fpc    <= {redirect_pc[63:2], 2'b00};
            case (state)
                WAIT:    state <= imem_ack ? IDLE : DROP;
                DROP:    state <= imem_ack ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            count <= count_next;
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        req_addr <= fpc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        fpc <= req_addr + 64'd4;
                        if (count_next < FULL) begin
                            req_addr <= req_addr + 64'd4;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Entry storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_addr;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch-side stage between a handshaked (variable-latency) instruction memory and the IF/ID pipeline register. It sequences fetch addresses, holds one outstanding memory request, and buffers up to DEPTH fetched {PC, instruction} pairs. It presents the oldest pair to decode through a valid/ready handshake, so hazard stalls do not throttle memory traffic. An EX/MEM branch redirect flushes the buffer and restarts fetch at the target, discarding any in-flight stale response.

## Interface
- DEPTH, 4: queue entries; power of 2, at least 2.
- RESET_PC, 64'd0: first fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  request valid; held high until imem_ack.
- imem_addr  out  64  request address; stable while imem_req is high.
- imem_ack  in  1  response valid; may arrive in the same cycle imem_req rises (zero-wait) or any later cycle.
- imem_rdata  in  32  instruction; sampled only when imem_ack=1.
- redirect  in  1  branch taken (branch_and_zero).
- redirect_pc  in  64  branch target; bits [1:0] are forced to 0 internally.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  decode accepts the head entry (IF_ID_Write).
- inst_out  out  32  head instruction.
- inst_pc  out  64  head PC.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: DEPTH-entry circular buffer of {pc[63:0], instr[31:0]}.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally.
  - count tracks occupancy (0..DEPTH).
- Registers: fpc is the next address to fetch. req_addr drives imem_addr.
- States:
  - IDLE: no outstanding request.
  - WAIT: request outstanding, response is wanted.
  - DROP: request outstanding, response must be discarded.
- imem_req = (state != IDLE).
- Pop: pop = inst_valid & inst_ready & ~redirect. A pop advances rd_ptr and decrements count.
- IDLE:
  - If ~redirect and count < DEPTH: req_addr <= fpc, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, with imem_ack=1 and ~redirect:
  - Push {req_addr, imem_rdata}.
  - fpc <= req_addr+4.
  - Let count_next = count + 1 - pop. If count_next < DEPTH: req_addr <= req_addr+4 and stay in WAIT (back-to-back). Otherwise go to IDLE.
- WAIT, with imem_ack=0: hold req_addr.
- Space guarantee: a request is issued or kept only when a free slot is reserved. A push therefore never hits a full buffer.
- Redirect (any state, highest priority):
  - Flush: count, rd_ptr and wr_ptr go to 0; no pop and no push that cycle.
  - fpc <= {redirect_pc[63:2], 2'b00}.
  - From IDLE: stay in IDLE.
  - From WAIT with imem_ack=1: the response is dropped; go to IDLE.
  - From WAIT with imem_ack=0: go to DROP; req_addr stays unchanged.
  - From DROP with imem_ack=1: go to IDLE. Without ack: stay in DROP.
- DROP: on imem_ack, discard imem_rdata and go to IDLE. Without ack, hold.
- Outputs:
  - inst_valid = (count != 0).
  - inst_out and inst_pc are combinational reads of entry rd_ptr.
  - Both are don't-care when inst_valid=0.
- Address arithmetic is 64-bit modulo 2^64; wrap past 0xFFFF_FFFF_FFFF_FFFC is silent.

## Timing
- Reset values: state=IDLE, fpc=RESET_PC, req_addr=RESET_PC, count=0, pointers=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0. Reset asserted mid-request abandons the request; the memory side must tolerate that.
- First request: imem_req rises in the first cycle after reset deasserts.
- Fetch latency: an entry becomes visible (inst_valid=1) in the cycle after its imem_ack edge.
- Throughput: with imem_ack tied high and inst_ready high, the block sustains 1 instruction per cycle.
- Latency with imem_ack tied high:
  - Reset release to first inst_valid: 2 cycles.
  - Redirect edge to first target instruction valid: 2 cycles (IDLE, then WAIT+ack).
- Full buffer:
  - Request issue stops after the push that fills the buffer.
  - Issue resumes 1 cycle after a pop leaves count < DEPTH (IDLE then WAIT).
- Same-edge events:
  - Push and pop together leave count unchanged.
  - Redirect overrides both push and pop.
- Occupancy bound: count never exceeds DEPTH; count equals DEPTH only with state=IDLE.

## Test plan
- Reset, RESET_PC=0x100, imem_ack tied high, inst_ready=1 -> inst_pc sequence 0x100, 0x104, 0x108, … on consecutive cycles; inst_valid first high 2 cycles after reset release.
- Memory ack latency 3 cycles, inst_ready=1 -> one entry every 3 cycles; imem_addr stable while imem_req is high; PCs increment by 4.
- inst_ready=0 for 10 cycles, DEPTH=4, ack tied high -> count saturates at 4 with imem_req=0. Then inst_ready=1 -> 4 entries drain in order with no PC gaps, and requests resume.
- Redirect to 0x2000 while 3 entries are queued and a request is outstanding (ack 2 cycles later) -> count=0 next cycle; state goes to DROP; the late response is discarded; the first valid inst_pc is 0x2000.
- Redirect in the same cycle as imem_ack and a pop -> no push and no pop; count=0; next request is to the target; the stale instruction never appears.
- Assert reset while in WAIT with 2 entries queued -> all outputs return to their reset values immediately; fetch restarts at RESET_PC.
